pixel_fetch_responder: RTL

//  Responder end of the pixel-fetch interface driven by the LED matrix controller.
//  - Accepts one byte-read request per cycle (address + valid) into a request FIFO.
//  - Issues the queued requests to the framebuffer RAM read port.
//  - Returns the read bytes to the controller in request order as single-cycle data strobes.
//  - Raises full back-pressure so the controller stalls its request sequence.

---
 rtl/pixel_fetch_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pixel_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fetch_responder
// Purpose  : Queues byte-read requests, issues them to the framebuffer RAM and
//            returns the bytes in request order. Optional macro
//            FETCH_OVERFLOW_EN adds the sticky overflow_err output.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fetch_responder #(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic                     req_valid,
  output logic                     req_full,
  output logic [7:0]               rsp_data,
  output logic                     rsp_valid,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_rd,
  input  logic                     ram_ready,
  input  logic [7:0]               ram_rdata,
  input  logic                     ram_rvalid
`ifdef FETCH_OVERFLOW_EN
  ,
  output logic                     overflow_err
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       C_MAX_OUT = 4'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_LIMIT = 2'd2;

  logic [ADDRESS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [3:0]               out_q, out_d;
  logic [1:0]               state_q, state_d;
  logic                     full_q, full_d;
  logic                     rsp_valid_q;
  logic [7:0]               rsp_data_q;

  logic w_push, w_accept, w_ret;

  assign w_push   = req_valid && !full_q;
  assign w_accept = (state_q == S_ISSUE) && ram_ready;
  // Returns with nothing outstanding (including data in flight across a reset) are dropped.
  assign w_ret    = ram_rvalid && (out_q != 4'd0);

  always_comb begin
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_accept);
    out_d   = out_q + 4'(w_accept) - 4'(w_ret);
    full_d  = (count_d == C_DEPTH);
    state_d = S_ISSUE;
    if (count_d == '0) begin
      state_d = S_IDLE;
    end else if (out_d == C_MAX_OUT) begin
      state_d = S_LIMIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      state_q     <= S_IDLE;
      full_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      out_q       <= out_d;
      state_q     <= state_d;
      full_q      <= full_d;
      rsp_valid_q <= w_ret;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_accept) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (w_ret) begin
        rsp_data_q <= ram_rdata;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= req_address;
    end
  end

`ifdef FETCH_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if ((req_valid && full_q) || (ram_rvalid && (out_q == 4'd0))) begin
      ovf_q <= 1'b1;
    end
  end
  assign overflow_err = ovf_q;
`endif

  // The head only moves on accept, so the address stays stable while waiting for ram_ready.
  assign ram_address = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign ram_rd      = (state_q == S_ISSUE);
  assign req_full    = full_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule
`default_nettype wire
